chn_loop_accum: RTL and testbench

Parametrised channel-loop accumulator for the conv datapath. It sums a run of LOOP_NUM consecutive LANES-wide partial-sum vectors, one per input-channel loop iteration. It then emits the per-lane totals with a one-cycle valid pulse and auto-clears, ready for the next group without a bubble. It sits after the PE array, in the slot the fixed 3-loop 64x16b self-add register heap occupies today, and adds:
- runtime loop count
- wider accumulators
- saturation
- overflow reporting

---
 rtl/chn_loop_accum.sv | 150 +++++++++++++++
 tb/tb_chn_loop_accum.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/chn_loop_accum.sv
// chn_loop_accum
//   Channel-loop accumulator for the conv datapath. Sums a run of loop_num
//   consecutive LANES-wide partial-sum vectors, then presents the per-lane
//   totals with a one-cycle valid pulse. The accumulators auto-clear, so the
//   next group can start in the same cycle the result is presented.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over halt/data_v)
//   halt      freeze: every register holds while high
//   data_v    in_data valid this cycle
//   in_data   LANES x IN_W signed lanes, lane k at [k*IN_W +: IN_W]
//   loop_num  group length, sampled on the first beat (0 behaves as 1)
//   out_v     result valid (held through halt, consumed on a non-halted cycle)
//   out_data  LANES x ACC_W signed sums, lane k at [k*ACC_W +: ACC_W]
//   out_ovf   some lane overflowed during the group, qualified by out_v
//   busy      group in progress
module chn_loop_accum #(
    parameter int LANES  = 64,
    parameter int IN_W   = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 4,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     halt,
    input  logic                     data_v,
    input  logic [LANES*IN_W-1:0]    in_data,
    input  logic [CNT_W-1:0]         loop_num,
    output logic                     out_v,
    output logic [LANES*ACC_W-1:0]   out_data,
    output logic                     out_ovf,
    output logic                     busy
);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, tgt_reg;
    logic [CNT_W-1:0]   tgt_first, cnt_inc;
    logic               ovf_reg, out_v_reg, out_ovf_reg;
    logic               accept, last_beat, finish, ovf_any, ovf_group;

    logic [ACC_W-1:0]   acc_reg      [LANES];
    logic [ACC_W-1:0]   out_lane_reg [LANES];
    logic [ACC_W-1:0]   lane_next    [LANES];
    logic [LANES-1:0]   lane_ovf;

    assign accept    = data_v & ~halt;
    assign tgt_first = (loop_num == '0) ? CNT_W'(1) : loop_num;
    assign cnt_inc   = cnt_reg + 1'b1;
    // The first beat of a group can also be its last when the length is 1.
    assign last_beat = (state_reg == IDLE) ? (tgt_first == CNT_W'(1))
                                           : (cnt_inc == tgt_reg);
    assign finish    = accept & last_beat;
    assign ovf_any   = |lane_ovf;
    // ovf_reg is always clear in IDLE, so no state qualification is needed.
    assign ovf_group = ovf_reg | ovf_any;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [IN_W-1:0]  in_lane;
            logic signed [ACC_W-1:0] acc_lane;
            logic signed [ACC_W:0]   sum;
            logic                    sum_ovf;

            assign in_lane  = in_data[gi*IN_W +: IN_W];
            assign acc_lane = acc_reg[gi];
            // One guard bit: the sum cannot wrap, so a mismatch between the
            // top two bits means the ACC_W-bit result overflowed.
            assign sum      = (ACC_W+1)'(acc_lane) + (ACC_W+1)'(in_lane);
            assign sum_ovf  = (sum[ACC_W] != sum[ACC_W-1]);

            // On the first beat the lane is loaded, not added, so it can
            // never overflow (ACC_W >= IN_W).
            assign lane_ovf[gi] = (state_reg == ACCUM) && sum_ovf;

            assign lane_next[gi] =
                (state_reg == IDLE)  ? ACC_W'(in_lane) :
                (sum_ovf && SAT_EN)  ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) :
                                       sum[ACC_W-1:0];

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg[gi]      <= '0;
                    out_lane_reg[gi] <= '0;
                end else begin
                    if (accept)
                        acc_reg[gi] <= finish ? '0 : lane_next[gi];
                    if (finish)
                        out_lane_reg[gi] <= lane_next[gi];
                end
            end

            assign out_data[gi*ACC_W +: ACC_W] = out_lane_reg[gi];
        end
    endgenerate

    // State register and group bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            tgt_reg     <= CNT_W'(1);
            ovf_reg     <= 1'b0;
            out_v_reg   <= 1'b0;
            out_ovf_reg <= 1'b0;
        end else if (!halt) begin
            state_reg <= state_next;
            out_v_reg <= finish;
            if (finish)
                out_ovf_reg <= ovf_group;
            if (accept) begin
                if (state_reg == IDLE)
                    tgt_reg <= tgt_first;
                if (finish) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else begin
                    cnt_reg <= (state_reg == IDLE) ? CNT_W'(1) : cnt_inc;
                    ovf_reg <= ovf_group;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            case (state_reg)
                IDLE:    if (!last_beat) state_next = ACCUM;
                ACCUM:   if (last_beat)  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy    = (state_reg == ACCUM);
        out_v   = out_v_reg;
        out_ovf = out_ovf_reg;
    end

endmodule

// File: tb/tb_chn_loop_accum.sv
module tb_chn_loop_accum;
    localparam int L  = 64;
    localparam int IW = 16;
    localparam int AW = 17;
    localparam int SMAX = (1 << (AW-1)) - 1;
    localparam int SMIN = -(1 << (AW-1));

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            halt = 1'b0;
    logic            data_v = 1'b0;
    logic [L*IW-1:0] in_data = '0;
    logic [3:0]      loop_num = '0;

    logic            out_v_s, out_v_w, out_ovf_s, out_ovf_w, busy_s, busy_w;
    logic [L*AW-1:0] out_data_s, out_data_w;

    chn_loop_accum #(.LANES(L), .IN_W(IW), .ACC_W(AW), .CNT_W(4), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .halt(halt), .data_v(data_v), .in_data(in_data),
        .loop_num(loop_num), .out_v(out_v_s), .out_data(out_data_s),
        .out_ovf(out_ovf_s), .busy(busy_s));

    chn_loop_accum #(.LANES(L), .IN_W(IW), .ACC_W(AW), .CNT_W(4), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .halt(halt), .data_v(data_v), .in_data(in_data),
        .loop_num(loop_num), .out_v(out_v_w), .out_data(out_data_w),
        .out_ovf(out_ovf_w), .busy(busy_w));

    always #5 clk = ~clk;

    typedef struct {
        logic [L*AW-1:0] sat;
        logic [L*AW-1:0] wrp;
        logic            ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int  n_tests = 0, n_fail = 0, n_groups = 0, n_deliv = 0;
    bit  m_busy = 0, m_ovf = 0;
    int  m_cnt = 0, m_tgt = 1;
    int  m_sat[L];
    int  m_wrp[L];
    bit  exp_busy = 0, exp_outv = 0;

    task automatic chk(input string tag, input bit ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    function automatic logic [L*IW-1:0] vec_all(input int v);
        logic [L*IW-1:0] d;
        for (int k = 0; k < L; k++) d[k*IW +: IW] = 16'(v);
        return d;
    endfunction

    function automatic logic [L*IW-1:0] vec_ramp();
        logic [L*IW-1:0] d;
        for (int k = 0; k < L; k++) d[k*IW +: IW] = 16'(k - 32);
        return d;
    endfunction

    function automatic bit model_beat(input logic [3:0] ln, input logic [L*IW-1:0] d);
        int   v, s;
        exp_t e;
        if (!m_busy) begin
            m_tgt = (ln == 0) ? 1 : int'(ln);
            m_cnt = 1;
            m_ovf = 0;
            for (int k = 0; k < L; k++) begin
                v = $signed(d[k*IW +: IW]);
                m_sat[k] = v;
                m_wrp[k] = v;
            end
        end else begin
            m_cnt++;
            for (int k = 0; k < L; k++) begin
                v = $signed(d[k*IW +: IW]);
                s = m_sat[k] + v;
                if (s > SMAX) begin s = SMAX; m_ovf = 1; end
                else if (s < SMIN) begin s = SMIN; m_ovf = 1; end
                m_sat[k] = s;
                m_wrp[k] = m_wrp[k] + v;
            end
        end
        if (m_cnt == m_tgt) begin
            e.sat = '0;
            e.wrp = '0;
            for (int k = 0; k < L; k++) begin
                e.sat[k*AW +: AW] = AW'(m_sat[k]);
                e.wrp[k*AW +: AW] = AW'(m_wrp[k]);
            end
            e.ovf = m_ovf;
            sb.push_back(e);
            n_groups++;
            m_busy = 0;
            return 1'b1;
        end
        m_busy = 1;
        return 1'b0;
    endfunction

    task automatic cyc(input bit dv, input bit h, input logic [3:0] ln, input logic [L*IW-1:0] d);
        bit fin;
        fin = 1'b0;
        data_v = dv; halt = h; loop_num = ln; in_data = d;
        if (dv && !h) fin = model_beat(ln, d);
        @(posedge clk); #1;
        exp_busy = m_busy;
        if (!h) exp_outv = fin;
    endtask

    task automatic do_reset();
        rst = 1'b1; data_v = 1'b0; halt = 1'b0;
        m_busy = 0; m_ovf = 0;
        @(posedge clk); #1;
        exp_busy = 0; exp_outv = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("busy_sat", busy_s === exp_busy);
        chk("busy_wrap", busy_w === exp_busy);
        chk("out_v_sat", out_v_s === exp_outv);
        chk("out_v_wrap", out_v_w === exp_outv);
        if (exp_outv && !halt && !rst) begin
            chk("sb_nonempty", sb.size() > 0);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_deliv++;
                chk("data_sat", out_data_s === mon_e.sat);
                chk("data_wrap", out_data_w === mon_e.wrp);
                chk("ovf_sat", out_ovf_s === mon_e.ovf);
                chk("ovf_wrap", out_ovf_w === mon_e.ovf);
                $display("[TB] result %0d lane0 sat=%0h wrap=%0h ovf=%0b",
                         n_deliv, out_data_s[AW-1:0], out_data_w[AW-1:0], out_ovf_s);
            end
        end
    end

    initial begin
        logic [L*IW-1:0] d;
        logic [3:0]      ln;

        do_reset();
        chk("rst_out_v", out_v_s === 1'b0);
        chk("rst_out_data", out_data_s === {(L*AW){1'b0}});
        chk("rst_out_ovf", out_ovf_s === 1'b0);
        chk("rst_busy", busy_s === 1'b0);
        chk("rst_out_data_w", out_data_w === {(L*AW){1'b0}});
        chk("rst_busy_w", busy_w === 1'b0);

        cyc(1, 0, 4'd3, vec_all(1));
        cyc(1, 0, 4'd3, vec_all(2));
        cyc(1, 0, 4'd3, vec_all(3));
        cyc(0, 0, 4'd0, '0);
        cyc(0, 0, 4'd0, '0);

        cyc(1, 0, 4'd0, vec_ramp());
        cyc(1, 0, 4'd1, vec_ramp());
        cyc(1, 0, 4'd0, vec_all(-7));
        cyc(1, 0, 4'd1, vec_all(7));
        cyc(0, 0, 4'd0, '0);

        d = '0;
        d[0 +: IW]  = 16'h7FFF;
        d[IW +: IW] = 16'h8000;
        for (int i = 0; i < 4; i++) cyc(1, 0, 4'd4, d);
        cyc(0, 0, 4'd0, '0);
        chk("sat_lane0", out_data_s[0 +: AW] === 17'h0FFFF);
        chk("sat_lane1", out_data_s[AW +: AW] === 17'h10000);
        chk("wrap_lane0", out_data_w[0 +: AW] === 17'h1FFFC);
        chk("wrap_lane1", out_data_w[AW +: AW] === 17'h00000);

        cyc(1, 0, 4'd3, vec_all(10));
        cyc(1, 0, 4'd7, vec_all(-20));
        for (int i = 0; i < 5; i++) cyc(1, 1, 4'd1, vec_all(1000));
        cyc(1, 0, 4'd1, vec_all(300));
        for (int i = 0; i < 5; i++) cyc(0, 1, 4'd0, '0);
        cyc(0, 0, 4'd0, '0);
        cyc(0, 0, 4'd0, '0);

        cyc(1, 0, 4'd3, vec_all(9));
        cyc(1, 0, 4'd3, vec_all(9));
        do_reset();
        cyc(1, 0, 4'd2, vec_all(5));
        cyc(1, 0, 4'd2, vec_all(5));
        cyc(0, 0, 4'd0, '0);
        chk("abort_lane5", out_data_s[5*AW +: AW] === 17'd10);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < L; k++) d[k*IW +: IW] = 16'($urandom);
            ln = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15))
                                             : 4'($urandom_range(0, 4));
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, ln, d);
        end
        for (int i = 0; i < 16 && m_busy; i++) cyc(1, 0, 4'd0, vec_all(i));
        for (int i = 0; i < 4; i++) cyc(0, 0, 4'd0, '0);

        chk("groups_delivered", n_deliv == n_groups);
        chk("sb_drained", sb.size() == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
